// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: opcodes, funct3 access sizes,
// fault codes and FSM states.
package mem_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size lives in the low two bits of funct3.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store steering, load extraction/extension,
// and legality/alignment checks for a given funct3 and address offset.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  fn_3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_val,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_val,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = load_word[{offset, 3'b000} +: 8];
  assign lane_half = offset[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    illegal = 1'b0;
    if (is_load)
      illegal = !(fn_3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else if (is_store)
      illegal = !(fn_3 inside {F3_B, F3_H, F3_W});
  end

  assign misaligned = ((fn_3[1:0] == SZ_HALF) && offset[0]) ||
                      ((fn_3[1:0] == SZ_WORD) && (offset != 2'b00));

  always_comb begin
    wdata = store_val;
    wstrb = 4'b1111;
    case (fn_3[1:0])
      SZ_BYTE: begin
        wdata = {4{store_val[7:0]}};
        wstrb = 4'b0001 << offset;
      end
      SZ_HALF: begin
        wdata = {2{store_val[15:0]}};
        wstrb = 4'b0011 << offset;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_val = 32'h0;
    case (fn_3)
      F3_B:    load_val = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_val = {{16{lane_half[15]}}, lane_half};
      F3_W:    load_val = load_word;
      F3_BU:   load_val = {24'h0, lane_byte};
      F3_HU:   load_val = {16'h0, lane_half};
      default: load_val = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers pass-through results, runs a req/ready
// handshake for loads/stores with a bus-timeout watchdog.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_valid,
  input  logic [6:0]        EX_opcode,
  input  logic [2:0]        EX_fn_3,
  input  logic [4:0]        EX_rd,
  input  logic [31:0]       EX_alu_val,
  input  logic [31:0]       EX_rs2_val,
  output logic              MEM_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              MEM_valid,
  output logic [4:0]        MEM_rd,
  output logic              MEM_wb_en,
  output logic [31:0]       MEM_wb_val,
  output logic [1:0]        MEM_fault
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic [2:0]  req_fn_3;
  logic [1:0]  req_offset;
  logic [4:0]  req_rd;
  logic        req_load;

  logic        is_load, is_store, is_mem, accept, start_req, timeout;
  logic [31:0] ex_wdata, ex_load_val, rsp_wdata, rsp_load_val;
  logic [3:0]  ex_wstrb, rsp_wstrb;
  logic        ex_misaligned, ex_illegal, rsp_misaligned, rsp_illegal;
  logic        unused_align;

  assign is_load   = (EX_opcode == OP_LOAD);
  assign is_store  = (EX_opcode == OP_STORE);
  assign is_mem    = is_load || is_store;
  assign accept    = (state == ST_IDLE) && EX_valid;
  assign start_req = accept && is_mem && !ex_illegal && !ex_misaligned;
  assign timeout   = (state == ST_REQ) && !dmem_ready && (wait_cnt == WAIT_LAST);
  assign MEM_stall = (state == ST_REQ);

  // Request side: checks and lane steering on the incoming instruction.
  mem_align u_align_req (
    .is_load    (is_load),
    .is_store   (is_store),
    .fn_3       (EX_fn_3),
    .offset     (EX_alu_val[1:0]),
    .store_val  (EX_rs2_val),
    .load_word  (32'h0),
    .wdata      (ex_wdata),
    .wstrb      (ex_wstrb),
    .load_val   (ex_load_val),
    .misaligned (ex_misaligned),
    .illegal    (ex_illegal)
  );

  // Response side: extraction from the returned word using the held access.
  mem_align u_align_rsp (
    .is_load    (req_load),
    .is_store   (!req_load),
    .fn_3       (req_fn_3),
    .offset     (req_offset),
    .store_val  (32'h0),
    .load_word  (dmem_rdata),
    .wdata      (rsp_wdata),
    .wstrb      (rsp_wstrb),
    .load_val   (rsp_load_val),
    .misaligned (rsp_misaligned),
    .illegal    (rsp_illegal)
  );

  assign unused_align = ^{ex_load_val, rsp_wdata, rsp_wstrb, rsp_misaligned, rsp_illegal};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_req) state_next = ST_REQ;
      ST_REQ:  if (dmem_ready || timeout) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= 8'd0;
      req_fn_3   <= 3'd0;
      req_offset <= 2'd0;
      req_rd     <= 5'd0;
      req_load   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 32'h0;
      dmem_wstrb <= 4'h0;
      MEM_valid  <= 1'b0;
      MEM_rd     <= 5'd0;
      MEM_wb_en  <= 1'b0;
      MEM_wb_val <= 32'h0;
      MEM_fault  <= FAULT_NONE;
    end else begin
      MEM_valid <= 1'b0;
      if (accept) begin
        if (start_req) begin
          wait_cnt   <= 8'd0;
          req_fn_3   <= EX_fn_3;
          req_offset <= EX_alu_val[1:0];
          req_rd     <= EX_rd;
          req_load   <= is_load;
          dmem_req   <= 1'b1;
          dmem_we    <= is_store;
          dmem_addr  <= {EX_alu_val[ADDR_W-1:2], 2'b00};
          dmem_wdata <= is_store ? ex_wdata : 32'h0;
          dmem_wstrb <= is_store ? ex_wstrb : 4'h0;
        end else begin
          MEM_valid  <= 1'b1;
          MEM_rd     <= EX_rd;
          MEM_wb_en  <= !is_mem && (EX_rd != 5'd0);
          MEM_wb_val <= is_mem ? 32'h0 : EX_alu_val;
          MEM_fault  <= !is_mem    ? FAULT_NONE :
                        ex_illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
        end
      end else if (state == ST_REQ) begin
        if (dmem_ready || timeout) begin
          dmem_req   <= 1'b0;
          dmem_we    <= 1'b0;
          dmem_addr  <= '0;
          dmem_wdata <= 32'h0;
          dmem_wstrb <= 4'h0;
          MEM_valid  <= 1'b1;
          MEM_rd     <= req_rd;
          MEM_wb_en  <= dmem_ready && req_load && (req_rd != 5'd0);
          MEM_wb_val <= (dmem_ready && req_load) ? rsp_load_val : 32'h0;
          MEM_fault  <= dmem_ready ? FAULT_NONE : FAULT_TIMEOUT;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage placed directly downstream of the ALU.
- Consumes the ALU result, opcode, fn_3, rd and the rs2 store value. Pass-through ops are registered to writeback in 1 cycle.
- LOAD/STORE ops run a request/ready handshake with the data memory, with byte-lane steering, load sign/zero extension and alignment checks.
- Stalls upstream while a memory access is outstanding. A watchdog flags a bus timeout.

Parameters:
- MAX_WAIT, 16, max cycles in REQ without dmem_ready before timeout fault (1..255)
- ADDR_W, 32, data-memory address width (low ADDR_W bits of ALU result used)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- EX_valid  in  1  instruction present on EX_* this cycle
- EX_opcode  in  7  RISC-V opcode (LOAD 0000011, STORE 0100011, others pass-through)
- EX_fn_3  in  3  funct3 (access size/sign)
- EX_rd  in  5  destination register
- EX_alu_val  in  32  ALU result: effective address for LOAD/STORE, else result
- EX_rs2_val  in  32  store data
- MEM_stall  out  1  upstream must hold EX_* stable while high
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_wdata  out  32  lane-steered store data
- dmem_wstrb  out  4  byte enables (0 for reads)
- dmem_ready  in  1  memory completes access this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready
- MEM_valid  out  1  one-cycle pulse: result/fault for one instruction
- MEM_rd  out  5  destination register
- MEM_wb_en  out  1  write rd (0 for stores, faults, rd==0)
- MEM_wb_val  out  32  writeback value
- MEM_fault  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal fn_3

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, MEM_valid, MEM_rd, MEM_wb_en, MEM_wb_val, MEM_fault, MEM_stall. Wait counter 0. Reset mid-access abandons the request; dmem_req drops immediately.
- States: IDLE, REQ.
- MEM_stall = (state==REQ). It is combinational from state only.
- Accept: IDLE && EX_valid, sampled at the clock edge.
- IDLE, non-memory opcode: next cycle MEM_valid=1, MEM_wb_val=EX_alu_val, MEM_rd=EX_rd, MEM_wb_en=(EX_rd!=0), MEM_fault=00.
- IDLE, memory op, fn_3 check:
  - Legal fn_3 (LOAD: 000,001,010,100,101; STORE: 000,001,010) and aligned → register dmem_* and enter REQ. dmem_req=1 from the next cycle.
  - Illegal fn_3 → next cycle MEM_valid=1, MEM_fault=11, wb_en=0. No request.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) → next cycle MEM_valid=1, MEM_fault=01, wb_en=0. No request.
- Store lane steering: SB wdata={4{rs2[7:0]}}, wstrb=0001<<addr[1:0]. SH wdata={2{rs2[15:0]}}, wstrb=0011<<addr[1:0]. SW wdata=rs2, wstrb=1111.
- REQ: dmem_req, we, addr, wdata and wstrb are held stable until dmem_ready=1. Ready may arrive in the first REQ cycle.
- On ready (edge): return to IDLE; next cycle MEM_valid=1.
- Load extract: byte/half selected by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend. Store: wb_en=0.
- Wait counter: cleared on REQ entry, increments each REQ cycle without ready. When it reaches MAX_WAIT without ready: dmem_req drops, state IDLE, next cycle MEM_valid=1, MEM_fault=10, wb_en=0. A dmem_ready that arrives late (outside REQ) is ignored.
- Latency: pass-through/fault 1 cycle. Memory op 2 + W cycles, where W = wait cycles before ready.
- Throughput: 1 instruction per cycle for pass-through; a memory op blocks new acceptance until back in IDLE.
- MEM_valid is a single-cycle pulse. MEM_rd, MEM_wb_val and MEM_fault hold until the next MEM_valid.

Decomposition:
- Shared package/header:
  - opcode constants (LOAD, STORE, R_TYPE, I_TYPE)
  - fn_3 size encodings
  - fault codes
  - state encodings
- Sub-module: mem_align (combinational). Store lane steering, load extraction/extension, and misalign/illegal detection. Instantiated once for each direction of use.

Test Plan:
- Pass-through: R-type, EX_alu_val=0x0000_1234, rd=5 → 1 cycle later MEM_valid=1, wb_val=0x1234, wb_en=1, no dmem_req.
- LB at 0x103, dmem_rdata=0x80AB_CDEF, ready on 2nd REQ cycle → dmem_addr=0x100, wb_val=0xFFFF_FF80; LBU same → 0x0000_0080; MEM_stall high exactly 2 cycles.
- SH at 0x202, rs2=0xDEAD_BEEF, ready immediately → dmem_we=1, wstrb=1100, wdata=0xBEEF_BEEF, MEM_valid with wb_en=0.
- LW at 0x301 → no dmem_req, MEM_fault=01 next cycle. Load with fn_3=011 → MEM_fault=11.
- Timeout: MAX_WAIT=4, ready never asserted → req held 4 cycles then dropped, MEM_fault=10; ready pulse 1 cycle later ignored.
- rst asserted mid-REQ → all outputs 0 immediately; after release, a fresh SW at 0x0 with rs2=0x1 completes with wstrb=1111.
